// File: rtl/inst_pipe_queue_pkg.sv
// Shared types and helpers for the multi-lane instruction queue.
package inst_pipe_queue_pkg;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned InstWidth = 32;
   localparam int unsigned MaxLanes  = 16;

   typedef struct packed {
      logic [AddrWidth-1:0] pc;
      logic [InstWidth-1:0] inst;
   } inst_entry_t;

   // Counts contiguous ones from bit 0 upward, looking at the low `width` bits only.
   function automatic int unsigned lead_ones(input logic [MaxLanes-1:0] mask,
                                             input int unsigned         width);
      int unsigned n;
      logic        run;
      n   = 0;
      run = 1'b1;
      for (int unsigned i = 0; i < MaxLanes; i++) begin
         if (i < width && run) begin
            if (mask[i]) n++;
            else         run = 1'b0;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/inst_pipe_queue_lane_cnt.sv
// Leading-ones counter over the enqueue lane-valid mask (lane 0 upward).
module inst_pipe_queue_lane_cnt
   import inst_pipe_queue_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0]           valid,
   output logic [$clog2(WIDTH+1)-1:0] cnt
);

   localparam int unsigned CntW = $clog2(WIDTH+1);

   logic [MaxLanes-1:0] mask;

   always_comb begin
      mask             = '0;
      mask[WIDTH-1:0]  = valid;
      cnt              = CntW'(lead_ones(mask, WIDTH));
   end

endmodule

// File: rtl/inst_pipe_queue.sv
// Multi-lane in-order instruction queue: up to IN_WIDTH enqueues and OUT_WIDTH dequeues per cycle.
module inst_pipe_queue
   import inst_pipe_queue_pkg::*;
#(
   parameter int unsigned ADDR      = AddrWidth,
   parameter int unsigned INST      = InstWidth,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned IN_WIDTH  = 2,
   parameter int unsigned OUT_WIDTH = 2
) (
   input  logic                           clk,
   input  logic                           reset_,
   input  logic                           flush,
   input  logic [IN_WIDTH-1:0]            in_valid,
   input  logic [IN_WIDTH*ADDR-1:0]       in_pc,
   input  logic [IN_WIDTH*INST-1:0]       in_inst,
   output logic                           in_ready,
   output logic [OUT_WIDTH-1:0]           out_valid,
   output logic [OUT_WIDTH*ADDR-1:0]      out_pc,
   output logic [OUT_WIDTH*INST-1:0]      out_inst,
   input  logic [$clog2(OUT_WIDTH+1)-1:0] out_pop,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned CntW   = $clog2(DEPTH+1);
   localparam int unsigned InCntW = $clog2(IN_WIDTH+1);

   typedef struct packed {
      logic [ADDR-1:0] pc;
      logic [INST-1:0] inst;
   } entry_t;

   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [InCntW-1:0] lane_cnt;
   logic [CntW-1:0]   n_in, n_out;
   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];

   inst_pipe_queue_lane_cnt #(
      .WIDTH (IN_WIDTH)
   ) u_lane_cnt (
      .valid (in_valid),
      .cnt   (lane_cnt)
   );

   // in_ready looks only at the registered count so out_pop never reaches it combinationally.
   always_comb begin
      in_ready = (count_q <= CntW'(DEPTH - IN_WIDTH));
      n_in     = (in_ready && !flush) ? CntW'(lane_cnt) : '0;

      n_out = CntW'(out_pop);
      if (n_out > count_q)            n_out = count_q;
      if (n_out > CntW'(OUT_WIDTH))   n_out = CntW'(OUT_WIDTH);
      if (flush)                      n_out = '0;

      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + n_in - n_out;
         rd_ptr_d = rd_ptr_q + PtrW'(n_out);
         wr_ptr_d = wr_ptr_q + PtrW'(n_in);
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int unsigned k = 0; k < IN_WIDTH; k++) begin
         if (CntW'(k) < n_in) begin
            mem_d[wr_ptr_q + PtrW'(k)].pc   = in_pc[k*ADDR +: ADDR];
            mem_d[wr_ptr_q + PtrW'(k)].inst = in_inst[k*INST +: INST];
         end
      end
   end

   always_comb begin
      out_valid = '0;
      out_pc    = '0;
      out_inst  = '0;
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
         if (count_q > CntW'(i)) begin
            out_valid[i]            = 1'b1;
            out_pc[i*ADDR +: ADDR]  = mem_q[rd_ptr_q + PtrW'(i)].pc;
            out_inst[i*INST +: INST] = mem_q[rd_ptr_q + PtrW'(i)].inst;
         end
      end
   end

   assign count = count_q;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
